// File: rtl/tm_qm0_rr_sched.sv
// Round-robin dequeue scheduler for first-level TM queues: tracks active queues from depth-tracker acks
// and issues one deq_req per grant. Optional stats ports under `TM_QM0_RR_SCHED_STATS_EN.
`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 4
`endif
module tm_qm0_rr_sched #(
  parameter int unsigned QID_NBITS     = `FIRST_LVL_QUEUE_ID_NBITS,
  parameter int unsigned ENQ_TRK_DEPTH = 8,
  parameter int unsigned DEQ_INFL_MAX  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enq_req_i,
  input  logic [QID_NBITS-1:0] enq_qid_i,
  input  logic                 enq_ack_i,
  input  logic                 enq_to_empty_i,
  input  logic                 deq_ack_i,
  input  logic                 deq_from_emptyp2_i,
  input  logic                 sch_ready_i,
  output logic                 deq_req_o,
  output logic [QID_NBITS-1:0] deq_qid_o,
  output logic                 sch_valid_o,
  output logic [QID_NBITS-1:0] sch_qid_o,
  output logic                 sch_err_o
`ifdef TM_QM0_RR_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_deq_cnt_o,
  output logic [QID_NBITS:0]   stat_act_hwm_o
`endif
);

  localparam int unsigned NQ  = 2**QID_NBITS;
  localparam int unsigned ETW = (ENQ_TRK_DEPTH > 1) ? $clog2(ENQ_TRK_DEPTH) : 1;
  localparam int unsigned IFW = (DEQ_INFL_MAX > 1) ? $clog2(DEQ_INFL_MAX) : 1;
  localparam int unsigned ICW = $clog2(DEQ_INFL_MAX + 1);

  typedef logic [QID_NBITS-1:0] qid_t;

  qid_t             etrk_mem_q [ENQ_TRK_DEPTH];
  logic [ETW-1:0]   etrk_wp_q, etrk_wp_d, etrk_rp_q, etrk_rp_d;
  logic [ETW:0]     etrk_cnt_q, etrk_cnt_d;

  qid_t             act_mem_q [NQ];
  qid_t             act_wp_q, act_wp_d, act_rp_q, act_rp_d, act_wp_b;
  logic [QID_NBITS:0] act_cnt_q, act_cnt_d;

  qid_t             ifl_mem_q [DEQ_INFL_MAX];
  logic [IFW-1:0]   ifl_wp_q, ifl_wp_d, ifl_rp_q, ifl_rp_d;
  logic [ICW-1:0]   ifl_cnt_q, ifl_cnt_d;

  logic deq_req_q, deq_req_d, sch_valid_q, sch_valid_d, err_q, err_d;
  qid_t deq_qid_q, deq_qid_d, sch_qid_q, sch_qid_d;

  logic etrk_empty, etrk_full, etrk_push, etrk_pop;
  logic ifl_empty, ifl_pop, grant, push_rq, push_act, dup;
  qid_t etrk_head, ifl_head, act_head;

  always_comb begin
    etrk_empty = (etrk_cnt_q == '0);
    etrk_full  = (etrk_cnt_q == (ETW+1)'(ENQ_TRK_DEPTH));
    etrk_push  = enq_req_i & ~etrk_full;
    etrk_pop   = enq_ack_i & ~etrk_empty;
    etrk_head  = etrk_mem_q[etrk_rp_q];
    ifl_empty  = (ifl_cnt_q == '0);
    ifl_pop    = deq_ack_i & ~ifl_empty;
    ifl_head   = ifl_mem_q[ifl_rp_q];
    act_head   = act_mem_q[act_rp_q];
    grant      = (act_cnt_q != '0) & sch_ready_i & (ifl_cnt_q < ICW'(DEQ_INFL_MAX));
    push_rq    = ifl_pop & deq_from_emptyp2_i;
    // Both pushes naming the same qid is a tracker protocol violation: flag it and keep one copy.
    dup        = push_rq & etrk_pop & enq_to_empty_i & (ifl_head == etrk_head);
    push_act   = etrk_pop & enq_to_empty_i & ~dup;
    act_wp_b   = push_rq ? act_wp_q + QID_NBITS'(1) : act_wp_q;

    etrk_wp_d  = etrk_push ? etrk_wp_q + ETW'(1) : etrk_wp_q;
    etrk_rp_d  = etrk_pop ? etrk_rp_q + ETW'(1) : etrk_rp_q;
    etrk_cnt_d = etrk_cnt_q + (ETW+1)'(etrk_push) - (ETW+1)'(etrk_pop);

    act_wp_d   = act_wp_q + QID_NBITS'(push_rq) + QID_NBITS'(push_act);
    act_rp_d   = grant ? act_rp_q + QID_NBITS'(1) : act_rp_q;
    act_cnt_d  = act_cnt_q + (QID_NBITS+1)'(push_rq) + (QID_NBITS+1)'(push_act)
               - (QID_NBITS+1)'(grant);

    ifl_wp_d   = ifl_wp_q;
    if (grant) ifl_wp_d = (ifl_wp_q == IFW'(DEQ_INFL_MAX-1)) ? '0 : ifl_wp_q + IFW'(1);
    ifl_rp_d   = ifl_rp_q;
    if (ifl_pop) ifl_rp_d = (ifl_rp_q == IFW'(DEQ_INFL_MAX-1)) ? '0 : ifl_rp_q + IFW'(1);
    ifl_cnt_d  = ifl_cnt_q + ICW'(grant) - ICW'(ifl_pop);

    deq_req_d   = grant;
    deq_qid_d   = grant ? act_head : deq_qid_q;
    sch_valid_d = ifl_pop;
    sch_qid_d   = ifl_pop ? ifl_head : sch_qid_q;
    err_d       = err_q | (enq_ack_i & etrk_empty) | (enq_req_i & etrk_full)
                | (deq_ack_i & ifl_empty) | dup;
  end

  always_ff @(posedge clk) begin
    if (etrk_push) etrk_mem_q[etrk_wp_q] <= enq_qid_i;
    if (push_rq)   act_mem_q[act_wp_q]   <= ifl_head;
    if (push_act)  act_mem_q[act_wp_b]   <= etrk_head;
    if (grant)     ifl_mem_q[ifl_wp_q]   <= act_head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      etrk_wp_q   <= '0;
      etrk_rp_q   <= '0;
      etrk_cnt_q  <= '0;
      act_wp_q    <= '0;
      act_rp_q    <= '0;
      act_cnt_q   <= '0;
      ifl_wp_q    <= '0;
      ifl_rp_q    <= '0;
      ifl_cnt_q   <= '0;
      deq_req_q   <= 1'b0;
      deq_qid_q   <= '0;
      sch_valid_q <= 1'b0;
      sch_qid_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      etrk_wp_q   <= etrk_wp_d;
      etrk_rp_q   <= etrk_rp_d;
      etrk_cnt_q  <= etrk_cnt_d;
      act_wp_q    <= act_wp_d;
      act_rp_q    <= act_rp_d;
      act_cnt_q   <= act_cnt_d;
      ifl_wp_q    <= ifl_wp_d;
      ifl_rp_q    <= ifl_rp_d;
      ifl_cnt_q   <= ifl_cnt_d;
      deq_req_q   <= deq_req_d;
      deq_qid_q   <= deq_qid_d;
      sch_valid_q <= sch_valid_d;
      sch_qid_q   <= sch_qid_d;
      err_q       <= err_d;
    end
  end

  assign deq_req_o   = deq_req_q;
  assign deq_qid_o   = deq_qid_q;
  assign sch_valid_o = sch_valid_q;
  assign sch_qid_o   = sch_qid_q;
  assign sch_err_o   = err_q;

`ifdef TM_QM0_RR_SCHED_STATS_EN
  logic [31:0]        stat_cnt_q;
  logic [QID_NBITS:0] stat_hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_q <= '0;
      stat_hwm_q <= '0;
    end else begin
      if (ifl_pop) stat_cnt_q <= stat_cnt_q + 32'd1;
      if (act_cnt_d > stat_hwm_q) stat_hwm_q <= act_cnt_d;
    end
  end

  assign stat_deq_cnt_o = stat_cnt_q;
  assign stat_act_hwm_o = stat_hwm_q;
`endif

endmodule
